// File: rtl/zjh_vote_ctrl.sv
// Three-voter majority session controller: timed sticky voting window,
// registered majority result and a fixed-length DONE display period.
module zjh_vote_ctrl #(
   parameter int VOTE_CYCLES = 16,
   parameter int HOLD_CYCLES = 8,
   parameter int EARLY_EXIT  = 1,
   parameter int CW          = 8
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic          START,
   input  logic          ABORT,
   input  logic          A,
   input  logic          B,
   input  logic          C,
   output logic          Y,
   output logic          DONE,
   output logic          BUSY,
   output logic [1:0]    YES_CNT,
   output logic [CW-1:0] REMAIN
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      VOTING = 2'd1,
      HOLD   = 2'd2
   } state_t;

   localparam logic [CW-1:0] VOTE_LOAD = CW'(VOTE_CYCLES);
   localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_CYCLES);
   localparam logic [CW-1:0] ONE       = CW'(1);

   state_t          state_reg, state_next;
   logic [2:0]      sticky_reg, sticky_next;
   logic [1:0]      cnt_reg, cnt_next;
   logic            y_reg, y_next;
   logic [CW-1:0]   remain_reg, remain_next;

   logic [2:0]      votes;
   logic [2:0]      sticky_upd;
   logic [1:0]      cnt_upd;
   logic            majority;

   assign votes = {C, B, A};

   // Each voter's yes is OR-ed into its own sticky bit; it can never clear mid-window.
   generate
      for (genvar gi = 0; gi < 3; gi++) begin : g_sticky
         assign sticky_upd[gi] = sticky_reg[gi] | votes[gi];
      end
   endgenerate

   assign cnt_upd  = {1'b0, sticky_upd[0]} + {1'b0, sticky_upd[1]} + {1'b0, sticky_upd[2]};
   assign majority = (cnt_upd >= 2'd2);

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_reg  <= IDLE;
         sticky_reg <= 3'b000;
         cnt_reg    <= 2'd0;
         y_reg      <= 1'b0;
         remain_reg <= '0;
      end else begin
         state_reg  <= state_next;
         sticky_reg <= sticky_next;
         cnt_reg    <= cnt_next;
         y_reg      <= y_next;
         remain_reg <= remain_next;
      end
   end

   always_comb begin
      state_next  = state_reg;
      sticky_next = sticky_reg;
      cnt_next    = cnt_reg;
      y_next      = y_reg;
      remain_next = remain_reg;

      case (state_reg)
         IDLE: begin
            if (START && !ABORT) begin
               state_next  = VOTING;
               sticky_next = 3'b000;
               cnt_next    = 2'd0;
               y_next      = 1'b0;
               remain_next = VOTE_LOAD;
            end
         end

         VOTING: begin
            sticky_next = sticky_upd;
            cnt_next    = cnt_upd;
            remain_next = remain_reg - ONE;
            // Exit decisions use this cycle's updated count, so the deciding vote counts.
            if (ABORT) begin
               state_next  = IDLE;
               y_next      = 1'b0;
               remain_next = '0;
            end else if ((remain_reg == ONE) || ((EARLY_EXIT != 0) && majority)) begin
               state_next  = HOLD;
               y_next      = majority;
               remain_next = HOLD_LOAD;
            end
         end

         HOLD: begin
            remain_next = remain_reg - ONE;
            if (ABORT || (remain_reg == ONE)) begin
               state_next  = IDLE;
               remain_next = '0;
            end
         end

         default: begin
            state_next  = IDLE;
            remain_next = '0;
         end
      endcase
   end

   assign Y       = y_reg;
   assign DONE    = (state_reg == HOLD);
   assign BUSY    = (state_reg == VOTING);
   assign YES_CNT = cnt_reg;
   assign REMAIN  = remain_reg;

endmodule
